button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 162 ++++++++++++++++
 tb/tb_button_conditioner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Debounce and edge-detect conditioning for the start and seed-load buttons.
// Each raw button goes through a 2-flop synchronizer and a qualification FSM.
// A confirmed press produces a registered one-cycle pulse. When both buttons
// confirm in the same cycle, start wins and the load pulse is dropped.

module button_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_i,
    output logic req_o,
    output logic level_o
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // A press is confirmed on the edge where PRESS_WAIT sees its last stable sample.
    always_comb begin
        req_o = (state_q == PRESS_WAIT) && s_i && (cnt_q == CNT_LAST);
    end

    // Qualification FSM: any disagreeing sample restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    if (s_i) begin
                        state_q <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                    if (!s_i) begin
                        state_q <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (s_i) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_q;

endmodule

module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_raw,
    input  logic btn_load_raw,
    output logic start,
    output logic lfsr_load,
    output logic start_level,
    output logic load_level
);

    logic [1:0] start_sync_q;
    logic [1:0] load_sync_q;
    logic       start_req;
    logic       load_req;
    logic       start_q;
    logic       load_q;

    // Two-flop synchronizers; bit 1 is the only version the FSMs ever see.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_sync_q <= '0;
            load_sync_q  <= '0;
        end else begin
            start_sync_q <= {start_sync_q[0], btn_start_raw};
            load_sync_q  <= {load_sync_q[0], btn_load_raw};
        end
    end

    button_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_start_fsm (
        .clk    (clk),
        .rst_n  (reset),
        .s_i    (start_sync_q[1]),
        .req_o  (start_req),
        .level_o(start_level)
    );

    button_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_load_fsm (
        .clk    (clk),
        .rst_n  (reset),
        .s_i    (load_sync_q[1]),
        .req_o  (load_req),
        .level_o(load_level)
    );

    // Registered pulses; a coincident load request is discarded, not deferred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            start_q <= start_req;
            load_q  <= load_req && !start_req;
        end
    end

    assign start     = start_q;
    assign lfsr_load = load_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner with a scoreboard.
module tb_button_conditioner;

    localparam int unsigned DC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_s = 1'b0;
    logic raw_l = 1'b0;
    logic start, lfsr_load, start_level, load_level;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .btn_start_raw(raw_s),
        .btn_load_raw (raw_l),
        .start        (start),
        .lfsr_load    (lfsr_load),
        .start_level  (start_level),
        .load_level   (load_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic st;
        logic ld;
        logic sl;
        logic ll;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int n_start = 0;
    int n_load = 0;
    int last_start_edge = -1;
    int last_load_edge = -1;

    // Reference model: raw sample history, confirmed level, and length of the
    // current run of samples that disagree with the confirmed level.
    logic [1:0]  hs = '0;
    logic [1:0]  hl = '0;
    logic        lvl_s = 1'b0;
    logic        lvl_l = 1'b0;
    int unsigned run_s = 0;
    int unsigned run_l = 0;

    task automatic chk(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0b expected %0b", nm, edge_n, act, req);
        end
    endtask

    task automatic chki(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, req);
        end
    endtask

    // A level flips once DC+1 consecutive samples disagree with it.
    task automatic qualify(input logic s, inout logic lvl, inout int unsigned run, output logic rise);
        rise = 1'b0;
        if (s == lvl) begin
            run = 0;
        end else begin
            run++;
            if (run == DC + 1) begin
                lvl  = s;
                run  = 0;
                rise = s;
            end
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic ps, pl;
        if (!rst_n) begin
            hs = '0; hl = '0; lvl_s = 1'b0; lvl_l = 1'b0; run_s = 0; run_l = 0;
            e = '0;
        end else begin
            qualify(hs[1], lvl_s, run_s, ps);
            qualify(hl[1], lvl_l, run_l, pl);
            hs = {hs[0], raw_s};
            hl = {hl[0], raw_l};
            e.st = ps;
            e.ld = pl && !ps;
            e.sl = lvl_s;
            e.ll = lvl_l;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic s, input logic l, input logic r);
        logic was;
        @(negedge clk);
        was   = rst_n;
        raw_s = s;
        raw_l = l;
        rst_n = r;
        if (was && !r) begin
            #1;
            chk("async_rst_start", start, 1'b0);
            chk("async_rst_load", lfsr_load, 1'b0);
            chk("async_rst_slevel", start_level, 1'b0);
            chk("async_rst_llevel", load_level, 1'b0);
        end
        @(posedge clk);
        edge_n++;
        model_step();
    endtask

    // Monitor: pop the expected response for every edge and compare.
    initial begin
        exp_t e;
        logic prev_s = 1'b0;
        logic prev_l = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("start", start, e.st);
                chk("lfsr_load", lfsr_load, e.ld);
                chk("start_level", start_level, e.sl);
                chk("load_level", load_level, e.ll);
                chk("exclusive", start && lfsr_load, 1'b0);
                chk("start_width", start && prev_s, 1'b0);
                chk("load_width", lfsr_load && prev_l, 1'b0);
                if (start) begin n_start++; last_start_edge = edge_n; end
                if (lfsr_load) begin n_load++; last_load_edge = edge_n; end
                prev_s = start;
                prev_l = lfsr_load;
            end
        end
    end

    initial begin
        int e0, ns0, nl0;
        logic vs, vl;

        // Reset state
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_start", start, 1'b0);
        chk("reset_load", lfsr_load, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);

        // Start held steadily: one pulse DC+2 edges after the first sampling edge
        ns0 = n_start; nl0 = n_load; e0 = edge_n + 1;
        repeat (10) cycle(1'b1, 1'b0, 1'b1);
        #2;
        chki("single_start_count", n_start - ns0, 1);
        chki("single_start_edge", last_start_edge, e0 + DC + 2);
        chki("single_start_noload", n_load - nl0, 0);
        chk("single_start_level", start_level, 1'b1);
        repeat (12) cycle(1'b0, 1'b0, 1'b1);

        // Bouncing load: high 2 / low 1, then held
        nl0 = n_load;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 1'b1);
        end
        #2;
        chki("bounce_no_load", n_load - nl0, 0);
        e0 = edge_n + 1;
        repeat (10) cycle(1'b0, 1'b1, 1'b1);
        #2;
        chki("bounce_final_count", n_load - nl0, 1);
        chki("bounce_final_edge", last_load_edge, e0 + DC + 2);
        repeat (12) cycle(1'b0, 1'b0, 1'b1);

        // Both rise together: start wins, load request discarded
        ns0 = n_start; nl0 = n_load;
        repeat (10) cycle(1'b1, 1'b1, 1'b1);
        #2;
        chki("both_start_count", n_start - ns0, 1);
        chki("both_load_count", n_load - nl0, 0);
        chk("both_slevel", start_level, 1'b1);
        chk("both_llevel", load_level, 1'b1);
        repeat (12) cycle(1'b0, 1'b0, 1'b1);

        // Short release keeps the button held; long release re-arms it
        ns0 = n_start;
        repeat (10) cycle(1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b1);
        #2;
        chki("short_release_count", n_start - ns0, 1);
        chk("short_release_level", start_level, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b1, 1'b0, 1'b1);
        #2;
        chki("long_release_count", n_start - ns0, 2);
        repeat (12) cycle(1'b0, 1'b0, 1'b1);

        // Reset mid-qualification with load still held
        nl0 = n_load;
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        e0 = edge_n + 1;
        repeat (10) cycle(1'b0, 1'b1, 1'b1);
        #2;
        chki("rst_requal_count", n_load - nl0, 1);
        chki("rst_requal_edge", last_load_edge, e0 + DC + 2);
        repeat (12) cycle(1'b0, 1'b0, 1'b1);

        // Random bouncing on both buttons, with one reset in the middle
        vs = 1'b0; vl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) vs = ~vs;
            if ($urandom_range(0, 5) == 0) vl = ~vl;
            cycle(vs, vl, (i >= 1500 && i < 1503) ? 1'b0 : 1'b1);
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        #2;
        chki("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
